// File: rtl/gamma_seq_pkg.sv
// Shared FSM state type and size helpers for the gamma sequencer.
// Sizes derive from the spike-time and weight resolutions.
package gamma_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRST,
    RUN,
    DONE
  } state_t;

  function automatic int gamma_len(
    input int tres,
    input int wres
  );
    return (1 << tres) + (1 << wres);
  endfunction

  function automatic int cnt_w(
    input int tres,
    input int wres
  );
    return $clog2(gamma_len(tres, wres) + 1);
  endfunction

endpackage

// File: rtl/gamma_sequencer_spike_pulse_gen.sv
// Per-input temporal pulse: high while cnt lies in [t, t+PW-1].
// Gated by the RUN phase and the latched enable.
module spike_pulse_gen #(
  parameter int TRES  = 3,
  parameter int WRES  = 3,
  parameter int CNT_W = 5
) (
  input  logic             active,
  input  logic             en,
  input  logic [TRES-1:0]  t,
  input  logic [CNT_W-1:0] cnt,
  output logic             pulse
);

  localparam int PW = 1 << WRES;

  logic [CNT_W:0] lo;
  logic [CNT_W:0] hi;
  logic [CNT_W:0] c;

  assign lo = (CNT_W+1)'(t);
  assign hi = lo + (CNT_W+1)'(PW - 1);
  assign c  = {1'b0, cnt};

  assign pulse = active && en && (c >= lo) && (c <= hi);

endmodule

// File: rtl/gamma_sequencer.sv
// Gamma-cycle sequencer: latches a spike volley, drives PW-wide pulses.
// Captures first neuron spike time. SEQ_EARLY_TERM_EN ends RUN on capture.
module gamma_sequencer
  import gamma_seq_pkg::*;
#(
  parameter  int INP   = 4,
  parameter  int WRES  = 3,
  parameter  int TRES  = 3,
  localparam int CNT_W = cnt_w(TRES, WRES)
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 start,
  output logic                 ready,
  input  logic [INP-1:0]       in_en,
  input  logic [INP*TRES-1:0]  in_time,
  output logic                 grst,
  output logic [INP-1:0]       spikes_out,
  input  logic                 output_spike,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [CNT_W-1:0]     result_time,
  output logic                 result_none
);

  localparam int GLEN = gamma_len(TRES, WRES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GLEN - 1);

  state_t               state;
  state_t               state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [INP-1:0]       en_q;
  logic [INP*TRES-1:0]  time_q;
  logic                 captured;
  logic                 accept;
  logic                 run;
  logic                 last;
  logic                 hit;

  assign ready        = (state == IDLE);
  assign grst         = (state == GRST);
  assign run          = (state == RUN);
  assign result_valid = (state == DONE);
  assign accept       = ready && start;
  assign last         = run && (cnt == LAST);
  assign hit          = run && output_spike && !captured;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = GRST;
      GRST: state_nx = RUN;
`ifdef SEQ_EARLY_TERM_EN
      RUN:  if (last || hit) state_nx = DONE;
`else
      RUN:  if (last) state_nx = DONE;
`endif
      DONE: if (result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      cnt         <= '0;
      en_q        <= '0;
      time_q      <= '0;
      captured    <= 1'b0;
      result_time <= '0;
      result_none <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        en_q     <= in_en;
        time_q   <= in_time;
        captured <= 1'b0;
      end
      if (grst) cnt <= '0;
      else if (run && !last) cnt <= cnt + 1'b1;
      // first spike wins; a miss is only resolved on the last RUN cycle
      if (hit) begin
        result_time <= cnt;
        result_none <= 1'b0;
        captured    <= 1'b1;
      end else if (last && !captured) begin
        result_time <= '1;
        result_none <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < INP; i++) begin : g_pg
    spike_pulse_gen #(
      .TRES  (TRES),
      .WRES  (WRES),
      .CNT_W (CNT_W)
    ) u_pg (
      .active (run),
      .en     (en_q[i]),
      .t      (time_q[i*TRES +: TRES]),
      .cnt    (cnt),
      .pulse  (spikes_out[i])
    );
  end

endmodule

// File: tb/tb_gamma_sequencer.sv
// Directed vector bench for gamma_sequencer (INP=4, WRES=3, TRES=3).
// Wave table plus hand sequences for reset, DONE hold and start timing.
module tb_gamma_sequencer;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start;
  logic        ready;
  logic [3:0]  in_en;
  logic [11:0] in_time;
  logic        grst;
  logic [3:0]  spikes_out;
  logic        output_spike;
  logic        result_valid;
  logic        result_ready;
  logic [4:0]  result_time;
  logic        result_none;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  en;
    logic [11:0] tim;
    int          sa;
    int          sb;
    logic [4:0]  et;
    logic        enone;
  } vec_t;

  vec_t vecs[6];

  gamma_sequencer #(
    .INP  (4),
    .WRES (3),
    .TRES (3)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .start        (start),
    .ready        (ready),
    .in_en        (in_en),
    .in_time      (in_time),
    .grst         (grst),
    .spikes_out   (spikes_out),
    .output_spike (output_spike),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_time  (result_time),
    .result_none  (result_none)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] model(
    input logic [3:0]  en,
    input logic [11:0] tim,
    input int          c
  );
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      int t;
      t = int'(tim[i*3 +: 3]);
      m[i] = en[i] && (c >= t) && (c <= t + 7);
    end
    return m;
  endfunction

  // Runs one wave up to the first DONE cycle (no handshake).
  task automatic wave(input vec_t v);
    int last;
    @(negedge clk);
    chk("idle_ready", ready, 1);
    start   = 1'b1;
    in_en   = v.en;
    in_time = v.tim;
    @(negedge clk);
    start        = 1'b0;
    in_en        = ~v.en;
    in_time      = ~v.tim;
    output_spike = 1'b1;
    chk("grst", grst, 1);
    chk("grst_ready", ready, 0);
    chk("grst_spk", spikes_out, 0);
    last = 15;
`ifdef SEQ_EARLY_TERM_EN
    if (v.sa >= 0 && v.sa < 15) last = v.sa;
`endif
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      output_spike = (c == v.sa) || (c == v.sb);
      chk("run_grst", grst, 0);
      chk("run_valid", result_valid, 0);
      chk("run_spk", spikes_out, model(v.en, v.tim, c));
    end
    @(negedge clk);
    output_spike = 1'b1;
    chk("done_valid", result_valid, 1);
    chk("done_time", result_time, v.et);
    chk("done_none", result_none, v.enone);
    chk("done_spk", spikes_out, 0);
    chk("done_ready", ready, 0);
  endtask

  task automatic release_done();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    output_spike = 1'b0;
    chk("rel_ready", ready, 1);
    chk("rel_valid", result_valid, 0);
  endtask

  initial begin
    vec_t h;
    vecs[0] = '{4'b0001, 12'h002, -1, -1, 5'd31, 1'b1};
    vecs[1] = '{4'b0000, 12'h5A3, -1, -1, 5'd31, 1'b1};
    vecs[2] = '{4'b1111, 12'hFFF,  7,  9, 5'd7,  1'b0};
    vecs[3] = '{4'b1111, 12'hFFF, -1, -1, 5'd31, 1'b1};
    vecs[4] = '{4'b1111, 12'hF58, 15, -1, 5'd15, 1'b0};
    vecs[5] = '{4'b1010, 12'h2C4,  0,  3, 5'd0,  1'b0};

    rstb = 1'b0;
    start = 1'b0;
    in_en = '0;
    in_time = '0;
    output_spike = 1'b0;
    result_ready = 1'b0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_grst", grst, 0);
    chk("rst_spk", spikes_out, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_none", result_none, 0);
    chk("rst_time", result_time, 0);
    @(negedge clk);
    rstb = 1'b1;

    for (int k = 0; k < 6; k++) begin
      wave(vecs[k]);
      release_done();
    end

    // asynchronous reset in the middle of RUN at cnt=5
    @(negedge clk);
    start = 1'b1;
    in_en = 4'b1111;
    in_time = 12'h000;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 5; c++) @(negedge clk);
    chk("mid_spk_pre", spikes_out, 4'b1111);
    #1 rstb = 1'b0;
    #1;
    chk("mid_ready", ready, 1);
    chk("mid_spk", spikes_out, 0);
    chk("mid_valid", result_valid, 0);
    chk("mid_grst", grst, 0);
    chk("mid_time", result_time, 0);
    @(negedge clk);
    chk("mid_ready2", ready, 1);
    rstb = 1'b1;
    wave(vecs[0]);
    release_done();

    // DONE held without result_ready; start and spikes must be ignored
    h = '{4'b0110, 12'h123, 4, 6, 5'd4, 1'b0};
    wave(h);
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      output_spike = ~k[0];
      @(negedge clk);
      chk("hold_valid", result_valid, 1);
      chk("hold_time", result_time, 4);
      chk("hold_none", result_none, 0);
      chk("hold_ready", ready, 0);
      chk("hold_grst", grst, 0);
    end
    output_spike = 1'b0;
    start = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("exit_ready", ready, 1);
    chk("exit_grst", grst, 0);
    @(negedge clk);
    start = 1'b0;
    chk("next_grst", grst, 1);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
